// File: rtl/irq_priority_ctrl.sv
// ---------------------------------------------------------------------------
// irq_priority_ctrl
//
// Interrupt controller for the SM83 core. Holds the IE and IF registers,
// edge-detects peripheral request lines, tracks the master enable (IME) with
// the one-instruction EI delay, and resolves the highest-priority pending
// source (bit 0 wins). A small request/acknowledge FSM hands the dispatch
// vector to the core's interrupt sequencer.
//
// Ports
//   CLK        in   1        core clock, rising edge
//   nRESET     in   1        asynchronous active-low reset
//   A          in   16       address bus
//   D_in       in   8        write data
//   D_out      out  8        read data (combinational, 0 when RD=0)
//   WR         in   1        write strobe
//   RD         in   1        read strobe
//   irq_in     in   NUM_IRQ  peripheral request levels
//   ei         in   1        EI executed pulse
//   di         in   1        DI executed pulse
//   instr_end  in   1        instruction boundary pulse
//   int_ack    in   1        sequencer acknowledge (level)
//   int_req    out  1        interrupt request to the sequencer
//   vec_valid  out  1        vec_out is valid
//   vec_out    out  8        dispatch vector low byte
//   wake       out  1        any enabled interrupt pending (ignores IME)
// ---------------------------------------------------------------------------
module irq_priority_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF,
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [15:0]        A,
    input  logic [7:0]         D_in,
    output logic [7:0]         D_out,
    input  logic               WR,
    input  logic               RD,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ei,
    input  logic               di,
    input  logic               instr_end,
    input  logic               int_ack,
    output logic               int_req,
    output logic               vec_valid,
    output logic [7:0]         vec_out,
    output logic               wake
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_VEC   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic               ime_q, ime_d;
    logic               ei_pend_q, ei_pend_d;
    logic [2:0]         idx_q, idx_d;
    logic               none_q, none_d;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] lowest_mask;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [2:0]         low_idx;
    logic               any_pending;
    logic               clear_en;
    logic               wr_ie;
    logic               wr_if;
    logic [7:0]         if_rd;
    logic [7:0]         vec_calc;

    assign pending     = ie_q[NUM_IRQ-1:0] & if_q;
    assign any_pending = |pending;
    assign wake        = any_pending;
    assign wr_ie       = WR && (A == IE_ADDR);
    assign wr_if       = WR && (A == IF_ADDR);

    // Two's-complement trick isolates the lowest set bit as a one-hot mask.
    assign lowest_mask = pending & (~pending + 1'b1);
    assign clr_mask    = clear_en ? lowest_mask : '0;

    always_comb begin
        low_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // IF read-back: unimplemented upper bits read as 1.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_if_rd
            if (gi < NUM_IRQ) begin : g_impl
                assign if_rd[gi] = if_q[gi];
            end else begin : g_unimpl
                assign if_rd[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        D_out = 8'h00;
        if (RD) begin
            if (A == IE_ADDR) begin
                D_out = ie_q;
            end else if (A == IF_ADDR) begin
                D_out = if_rd;
            end
        end
    end

    assign vec_calc = VEC_BASE + 8'(idx_q) * 8'(VEC_STRIDE);

    // Dispatch FSM: next state and outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        none_d    = none_q;
        int_req   = 1'b0;
        vec_valid = 1'b0;
        vec_out   = 8'h00;
        clear_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                int_req = ime_q & any_pending;
                if (int_ack && ime_q && any_pending) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Priority is resolved here; IE/IF may have changed since
                // the request, in which case nothing is left to service.
                idx_d    = low_idx;
                none_d   = ~any_pending;
                clear_en = any_pending;
                state_d  = ST_VEC;
            end
            ST_VEC: begin
                vec_valid = 1'b1;
                vec_out   = none_q ? 8'h00 : vec_calc;
                if (!int_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register next-state: bus write, then service clear, then edge set
    // (a same-cycle edge always wins).
    always_comb begin
        ie_d = wr_ie ? D_in : ie_q;
        if_d = if_q;
        if (wr_if) begin
            if_d = D_in[NUM_IRQ-1:0];
        end
        if_d = (if_d & ~clr_mask) | edge_q;
    end

    // IME: EI arms a pending enable that matures on a later instruction
    // boundary; DI and interrupt entry cancel both immediately.
    always_comb begin
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        if (di || (state_q == ST_LATCH)) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end else begin
            if (ei_pend_q && instr_end) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (ei) begin
                ei_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            ie_q       <= 8'h00;
            if_q       <= '0;
            irq_prev_q <= '0;
            edge_q     <= '0;
            ime_q      <= 1'b0;
            ei_pend_q  <= 1'b0;
            idx_q      <= 3'd0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            if_q       <= if_d;
            irq_prev_q <= irq_in;
            edge_q     <= irq_in & ~irq_prev_q;
            ime_q      <= ime_d;
            ei_pend_q  <= ei_pend_d;
            idx_q      <= idx_d;
            none_q     <= none_d;
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic        WR, RD, ei, di, instr_end, int_ack;
    logic [4:0]  irq_in;
    logic [7:0]  irq_in8;
    logic [7:0]  D_out, vec_out, D_out8, vec_out8;
    logic        int_req, vec_valid, wake;
    logic        int_req8, vec_valid8, wake8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    irq_priority_ctrl dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(D_out),
        .WR(WR), .RD(RD), .irq_in(irq_in), .ei(ei), .di(di),
        .instr_end(instr_end), .int_ack(int_ack), .int_req(int_req),
        .vec_valid(vec_valid), .vec_out(vec_out), .wake(wake)
    );

    irq_priority_ctrl #(.NUM_IRQ(8), .VEC_STRIDE(8)) dut8 (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(D_out8),
        .WR(WR), .RD(RD), .irq_in(irq_in8), .ei(ei), .di(di),
        .instr_end(instr_end), .int_ack(int_ack), .int_req(int_req8),
        .vec_valid(vec_valid8), .vec_out(vec_out8), .wake(wake8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (NUM_IRQ = 5 instance) ----------------
    localparam int P_IDLE = 0, P_LATCH = 1, P_VEC = 2;
    logic [7:0] m_ie;
    logic [4:0] m_if, m_prev, m_edge;
    bit         m_ime, m_eip, m_none;
    int         m_phase, m_idx;

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ie = 8'h00; m_if = '0; m_prev = '0; m_edge = '0;
        m_ime = 0; m_eip = 0; m_none = 0; m_phase = P_IDLE; m_idx = 0;
    endtask

    task automatic model_check();
        logic [4:0] pend;
        logic [7:0] e_dout, e_vo;
        bit e_req;
        pend   = m_ie[4:0] & m_if;
        e_req  = (m_phase == P_IDLE) && m_ime && (pend != 0);
        e_vo   = (m_phase == P_VEC && !m_none) ? 8'((32'h40 + m_idx * 8) % 256) : 8'h00;
        e_dout = 8'h00;
        if (RD && A == 16'hFFFF) e_dout = m_ie;
        else if (RD && A == 16'hFF0F) e_dout = {3'b111, m_if};
        check_eq("int_req", 32'(int_req), 32'(e_req));
        check_eq("vec_valid", 32'(vec_valid), 32'(m_phase == P_VEC));
        check_eq("vec_out", 32'(vec_out), 32'(e_vo));
        check_eq("wake", 32'(wake), 32'(pend != 0));
        check_eq("D_out", 32'(D_out), 32'(e_dout));
    endtask

    task automatic model_step();
        logic [4:0] pend, n_if;
        bit req;
        int k;
        if (!nRESET) begin
            model_reset();
            return;
        end
        pend = m_ie[4:0] & m_if;
        req  = (m_phase == P_IDLE) && m_ime && (pend != 0);
        n_if = m_if;
        if (WR && A == 16'hFF0F) n_if = D_in[4:0];
        if (m_phase == P_LATCH) begin
            k = lowest(pend);
            m_none = (k < 0);
            m_idx  = (k < 0) ? 0 : k;
            if (k >= 0) n_if[k] = 1'b0;
            $display("dispatch source=%0d none=%0d vec=%02h", m_idx, m_none,
                     m_none ? 8'h00 : 8'((32'h40 + m_idx * 8) % 256));
        end
        n_if = n_if | m_edge;
        if (WR && A == 16'hFFFF) m_ie = D_in;
        m_edge = irq_in & ~m_prev;
        m_prev = irq_in;
        if (di || m_phase == P_LATCH) begin
            m_ime = 0; m_eip = 0;
        end else begin
            if (m_eip && instr_end) begin m_ime = 1; m_eip = 0; end
            if (ei) m_eip = 1;
        end
        case (m_phase)
            P_IDLE:  if (int_ack && req) m_phase = P_LATCH;
            P_LATCH: m_phase = P_VEC;
            default: if (!int_ack) m_phase = P_IDLE;
        endcase
        m_if = n_if;
    endtask

    // One clock: called at negedge with inputs set; checks, advances, clears strobes.
    task automatic cyc();
        #1;
        if (!nRESET) model_reset();
        model_check();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        WR = 0; RD = 0; ei = 0; di = 0; instr_end = 0;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] val);
        WR = 1; A = addr; D_in = val;
        cyc();
    endtask

    initial begin
        nRESET = 0; A = 16'h0000; D_in = 8'h00; WR = 0; RD = 0;
        ei = 0; di = 0; instr_end = 0; int_ack = 0; irq_in = '0; irq_in8 = '0;
        model_reset();
        @(negedge CLK);
        RD = 1; A = 16'hFF0F; #1;
        check_eq("reset_if_read", 32'(D_out), 32'h0E0);
        check_eq("reset_int_req", 32'(int_req), 32'h0);
        cyc();
        nRESET = 1;

        // Priority: sources 2 and 4 rise together, source 2 wins.
        wr_reg(16'hFFFF, 8'h1F);
        ei = 1; cyc();
        instr_end = 1; cyc();
        irq_in = 5'b10100; cyc();
        #1 check_eq("req_latency_1clk", 32'(int_req), 32'h0);
        cyc();
        RD = 1; A = 16'hFF0F; #1;
        check_eq("req_latency_2clk", 32'(int_req), 32'h1);
        check_eq("if_before_ack", 32'(D_out), 32'h0F4);
        int_ack = 1; cyc();
        cyc();
        RD = 1; A = 16'hFF0F; #1;
        check_eq("prio_vec", 32'(vec_out), 32'h050);
        check_eq("prio_vec_valid", 32'(vec_valid), 32'h1);
        check_eq("if_after_ack", 32'(D_out), 32'h0F0);
        int_ack = 0; cyc();
        #1 check_eq("ime_cleared_req", 32'(int_req), 32'h0);
        check_eq("ime_cleared_wake", 32'(wake), 32'h1);
        cyc();

        // Service source 4, then reset in the middle of VEC.
        ei = 1; cyc();
        instr_end = 1; cyc();
        #1 check_eq("reenable_req", 32'(int_req), 32'h1);
        int_ack = 1; cyc();
        cyc();
        #1 check_eq("src4_vec", 32'(vec_out), 32'h060);
        nRESET = 0; RD = 1; A = 16'hFFFF; #1;
        check_eq("rst_vec_valid", 32'(vec_valid), 32'h0);
        check_eq("rst_int_req", 32'(int_req), 32'h0);
        check_eq("rst_ie_read", 32'(D_out), 32'h000);
        cyc();
        RD = 1; A = 16'hFF0F; #1;
        check_eq("rst_if_read", 32'(D_out), 32'h0E0);
        cyc();
        nRESET = 1; int_ack = 0; irq_in = '0; cyc();

        // EI delay and DI precedence.
        wr_reg(16'hFFFF, 8'h1F);
        irq_in = 5'b00001; cyc();
        cyc();
        #1 check_eq("ei_pre_wake", 32'(wake), 32'h1);
        check_eq("ei_pre_req", 32'(int_req), 32'h0);
        ei = 1; instr_end = 1; cyc();
        #1 check_eq("ei_same_end", 32'(int_req), 32'h0);
        cyc();
        instr_end = 1; cyc();
        #1 check_eq("ei_second_end", 32'(int_req), 32'h1);
        di = 1; cyc();
        #1 check_eq("di_clears", 32'(int_req), 32'h0);
        ei = 1; di = 1; cyc();
        instr_end = 1; cyc();
        instr_end = 1; cyc();
        #1 check_eq("di_wins", 32'(int_req), 32'h0);

        // Lost request: IE cleared in the acknowledge cycle.
        ei = 1; cyc();
        instr_end = 1; cyc();
        #1 check_eq("lost_req_up", 32'(int_req), 32'h1);
        int_ack = 1; WR = 1; A = 16'hFFFF; D_in = 8'h00; cyc();
        cyc();
        RD = 1; A = 16'hFF0F; #1;
        check_eq("lost_vec_valid", 32'(vec_valid), 32'h1);
        check_eq("lost_vec_out", 32'(vec_out), 32'h000);
        check_eq("lost_if_kept", 32'(D_out), 32'h0E1);
        int_ack = 0; cyc();
        cyc();

        // Collision: IF write lands in the same cycle as source 2's edge.
        wr_reg(16'hFFFF, 8'h1F);
        irq_in = 5'b00101; cyc();
        wr_reg(16'hFF0F, 8'h00);
        RD = 1; A = 16'hFF0F; #1;
        check_eq("collide_if", 32'(D_out), 32'h0E4);
        check_eq("collide_wake", 32'(wake), 32'h1);
        check_eq("collide_req", 32'(int_req), 32'h0);
        cyc();

        // NUM_IRQ=8 instance: no forced-1 bits, source 7 vector.
        nRESET = 0; irq_in = '0; irq_in8 = '0; cyc();
        nRESET = 1; RD = 1; A = 16'hFF0F; #1;
        check_eq("p8_if_read", 32'(D_out8), 32'h000);
        cyc();
        wr_reg(16'hFFFF, 8'h80);
        ei = 1; cyc();
        instr_end = 1; cyc();
        irq_in8 = 8'h80; cyc();
        cyc();
        #1 check_eq("p8_req", 32'(int_req8), 32'h1);
        int_ack = 1; cyc();
        cyc();
        #1 check_eq("p8_vec", 32'(vec_out8), 32'h078);
        check_eq("p8_vec_valid", 32'(vec_valid8), 32'h1);
        int_ack = 0; cyc();
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            nRESET = ($urandom_range(0, 499) != 0);
            WR = ($urandom_range(0, 5) == 0);
            RD = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: A = 16'hFFFF;
                1, 2: A = 16'hFF0F;
                default: A = 16'($urandom);
            endcase
            D_in = 8'($urandom);
            if (WR && A == 16'hFFFF && $urandom_range(0, 1) == 1) D_in[4:0] = 5'h1F;
            ei = ($urandom_range(0, 7) == 0);
            di = ($urandom_range(0, 15) == 0);
            instr_end = ($urandom_range(0, 2) == 0);
            int_ack = $urandom_range(0, 1);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
